// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - board RAM arbiter between VGA tile fetch and game logic
// VGA reads are never dropped silently; game starvation is bounded by wait_cnt.
module board_mem_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_re,
   input  logic [ADDR_W-1:0] vga_raddr,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_rvalid,
   output logic              vga_overrun,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_gnt,
   output logic [DATA_W-1:0] game_rdata,
   output logic              game_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   logic              vga_pend;
   logic [ADDR_W-1:0] vga_addr_q;
   logic [3:0]        wait_cnt;
   logic              rd_valid;
   logic              rd_game;

   logic              vga_cand;
   logic [ADDR_W-1:0] vga_cand_addr;
   logic              game_win;
   logic              vga_win;

   always_comb begin
      vga_cand      = vga_pend | vga_re;
      vga_cand_addr = vga_pend ? vga_addr_q : vga_raddr;
      game_win      = game_req && (!vga_cand || (wait_cnt == MAX_W));
      vga_win       = vga_cand && !game_win;

      game_gnt  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      // The RAM port is forced quiet while reset is held, even with live requests.
      if (!reset) begin
         if (game_win) begin
            game_gnt  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = game_we;
            mem_addr  = game_addr;
            mem_wdata = game_we ? game_wdata : '0;
         end else if (vga_win) begin
            mem_en   = 1'b1;
            mem_addr = vga_cand_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_pend    <= 1'b0;
         vga_addr_q  <= '0;
         wait_cnt    <= '0;
         rd_valid    <= 1'b0;
         rd_game     <= 1'b0;
         vga_rdata   <= '0;
         game_rdata  <= '0;
         vga_rvalid  <= 1'b0;
         game_rvalid <= 1'b0;
         vga_overrun <= 1'b0;
      end else begin
         if (!game_req || game_gnt)
            wait_cnt <= '0;
         else if (wait_cnt < MAX_W)
            wait_cnt <= wait_cnt + 4'd1;

         rd_valid    <= mem_en & ~mem_we;
         rd_game     <= game_win;
         vga_rvalid  <= rd_valid & ~rd_game;
         game_rvalid <= rd_valid & rd_game;
         if (rd_valid && !rd_game)
            vga_rdata <= mem_rdata;
         if (rd_valid && rd_game)
            game_rdata <= mem_rdata;

         // A new request arriving while the pending slot is served refills the slot.
         if (vga_win) begin
            vga_pend <= vga_pend & vga_re;
            if (vga_pend && vga_re)
               vga_addr_q <= vga_raddr;
         end else if (vga_re) begin
            vga_pend   <= 1'b1;
            vga_addr_q <= vga_raddr;
            if (vga_pend)
               vga_overrun <= 1'b1;
         end
      end
   end

endmodule
